sprite_renderer: RTL
====================

Name: sprite_renderer

Overview:
- Per-pixel sprite compositor directly downstream of the location-to-pixel conversion stage.
- Consumes per-sprite screen centers (rows/cols) and the VGA scan position. Reports whether the current pixel lies inside a circular sprite, and which sprite.
- Latches centers once per frame so sprites never tear mid-scan.
- Counts frames and flags sprite overlap per frame for the physics/debug path.

Parameters:
SPRITES, 9, number of sprites
RADIUS, 16, sprite radius in pixels; hit when dx^2+dy^2 <= RADIUS^2
H_ACTIVE, 1600, visible columns; center col >= H_ACTIVE means sprite disabled
V_ACTIVE, 1200, visible rows; center row >= V_ACTIVE means sprite disabled

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rows  in  [SPRITES][11]  sprite center rows; off-screen sentinel 1300
cols  in  [SPRITES][12]  sprite center cols; off-screen sentinel 1700
frame_start  in  1  one-cycle pulse at start of vertical blank
vga_row  in  11  current scan row
vga_col  in  12  current scan column
blank  in  1  1 = not in visible region
hit  out  1  current (delayed) pixel is inside a sprite
sprite_idx  out  $clog2(SPRITES)  lowest-index sprite hit; 0 when hit=0
pix_valid  out  1  pipeline output corresponds to a visible pixel
frame_count  out  16  frames started since reset, wraps 0xFFFF->0
overlap  out  1  previous frame had at least one pixel hit by two or more sprites

Behaviour:
- Reset:
  - All outputs 0.
  - Shadow centers = (1300, 1700) for every sprite.
  - Pipeline valid bits 0; overlap accumulator 0.
  - Reset has priority over frame_start in the same cycle.
- Center latch:
  - On a clock edge with frame_start=1, shadow rows/cols <= rows/cols.
  - Otherwise shadows hold; input changes mid-frame have no visible effect.
- Pipeline: 3 cycles; inputs (vga_row, vga_col, blank) at edge N produce outputs after edge N+3. One pixel per cycle, no stalls.
  - S1: per sprite, signed 13-bit dx = vga_col - col, dy = vga_row - row; register |dx|, |dy|, plus en = (col < H_ACTIVE && row < V_ACTIVE). Register blank.
  - S2: near = en && |dx| <= RADIUS && |dy| <= RADIUS; d2 = |dx|^2 + |dy|^2 at width 2*($clog2(RADIUS+1))+1; hitvec[i] = near && d2 <= RADIUS^2. Squares use only the bounded low bits.
  - S3:
    - hit = |hitvec && !blank_d2.
    - sprite_idx = lowest set index, else 0.
    - pix_valid = !blank_d2.
    - multi = popcount(hitvec) >= 2 && !blank_d2.
- Overlap:
  - An accumulator ORs in multi every cycle.
  - On frame_start, overlap <= accumulator (including a multi in the same cycle) and the accumulator clears.
  - overlap holds until the next frame_start.
- frame_count increments on each frame_start edge; wraps silently.
- Pixels in flight during frame_start use the new shadows from the cycle after the latch. frame_start arrives in blank, so visible output is unaffected.
- Sprites partially off-edge, e.g. center col 5: negative dx is handled by signed subtraction, and pixels at col 0 can hit.

Test Plan:
- Reset, then frame_start with sprite0 = (600,800), others sentinel. Pixels (600,800), (600,816), (600,817) at consecutive cycles -> hit = 1,1,0 exactly 3 cycles later; sprite_idx = 0.
- Diagonal boundary, sprite0 at (600,800): (611,811), d2=242 -> hit=1; (612,812), d2=288 -> hit=0; (588,789), d2=265 -> hit=0.
- Sprites 2 and 5 both at (100,100), frame_start, scan (100,100) -> hit=1, sprite_idx=2. overlap stays 0 until next frame_start, then 1. A following clean frame -> overlap returns to 0.
- Latch isolation: after frame_start, change sprite0 col to 300 and scan (600,800) -> still hit. Scan (600,300) -> miss. After next frame_start the results swap.
- Sentinel/blank:
  - Sprite at (1300,1700), scan (1199,1599) -> hit=0.
  - blank=1 while on sprite0's center -> hit=0, pix_valid=0.
  - Sprite at (600,5), pixel (600,0) -> hit=1.
- Reset mid-frame: assert reset with a hit in flight -> hit, pix_valid, frame_count, overlap all 0 next cycle. With no frame_start yet, scan (600,800) -> hit=0. Reset together with frame_start -> frame_count stays 0.

Source files
------------

// File: rtl/sprite_renderer_if.sv
// Pixel-stream bundle between the VGA scan source and the sprite renderer:
// scan position/blank in one direction, hit result out the other.
interface sprite_renderer_if #(
    parameter int SPRITES = 9
);
    localparam int IDX_W = (SPRITES > 1) ? $clog2(SPRITES) : 1;

    logic [10:0]      vga_row;
    logic [11:0]      vga_col;
    logic             blank;
    logic             hit;
    logic [IDX_W-1:0] sprite_idx;
    logic             pix_valid;

    modport master (
        output vga_row, vga_col, blank,
        input  hit, sprite_idx, pix_valid
    );

    modport slave (
        input  vga_row, vga_col, blank,
        output hit, sprite_idx, pix_valid
    );
endinterface

// File: rtl/sprite_renderer.sv
// Per-pixel circular sprite compositor: 3-stage hit pipeline against
// frame-latched sprite centers, plus frame counter and per-frame overlap flag.
module sprite_renderer #(
    parameter int SPRITES  = 9,
    parameter int RADIUS   = 16,
    parameter int H_ACTIVE = 1600,
    parameter int V_ACTIVE = 1200
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [SPRITES-1:0][10:0] rows,
    input  logic [SPRITES-1:0][11:0] cols,
    input  logic                     frame_start,
    sprite_renderer_if.slave         px,
    output logic [15:0]              frame_count,
    output logic                     overlap
);
    localparam int IDX_W = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam int SQ_W  = $clog2(RADIUS + 1);
    localparam int D2_W  = 2 * SQ_W + 1;

    localparam logic [10:0]     ROW_OFF = 11'd1300;
    localparam logic [11:0]     COL_OFF = 12'd1700;
    localparam logic [11:0]     RAD12   = 12'(RADIUS);
    localparam logic [D2_W-1:0] RAD_SQ  = D2_W'(RADIUS * RADIUS);
    localparam logic [11:0]     H_LIM   = 12'(H_ACTIVE);
    localparam logic [10:0]     V_LIM   = 11'(V_ACTIVE);

    function automatic logic [11:0] abs13(input logic [12:0] v);
        logic [12:0] n;
        n = 13'd0 - v;
        abs13 = v[12] ? n[11:0] : v[11:0];
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [SPRITES-1:0] v);
        lowest_idx = '0;
        for (int i = SPRITES - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    endfunction

    function automatic logic at_least_two(input logic [SPRITES-1:0] v);
        logic seen;
        seen = 1'b0;
        at_least_two = 1'b0;
        for (int i = 0; i < SPRITES; i++) begin
            if (v[i]) begin
                at_least_two = at_least_two | seen;
                seen = 1'b1;
            end
        end
    endfunction

    logic [SPRITES-1:0][10:0] row_sh_q, row_sh_d;
    logic [SPRITES-1:0][11:0] col_sh_q, col_sh_d;
    logic [SPRITES-1:0][11:0] adx_q, adx_d, ady_q, ady_d;
    logic [SPRITES-1:0]       en_q, en_d;
    logic                     blank1_q, blank1_d;
    logic [SPRITES-1:0]       hitvec_q, hitvec_d;
    logic                     blank2_q, blank2_d;
    logic                     hit_q, hit_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     pix_valid_q, pix_valid_d;
    logic                     multi_q, multi_d;
    logic                     acc_q, acc_d;
    logic                     overlap_q, overlap_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;

    // Center latch, frame counter and overlap accumulator next-state
    always_comb begin
        row_sh_d    = row_sh_q;
        col_sh_d    = col_sh_q;
        frame_cnt_d = frame_cnt_q;
        overlap_d   = overlap_q;
        acc_d       = acc_q | multi_q;
        if (frame_start) begin
            row_sh_d    = rows;
            col_sh_d    = cols;
            frame_cnt_d = frame_cnt_q + 16'd1;
            overlap_d   = acc_q | multi_q;
            acc_d       = 1'b0;
        end else begin
            row_sh_d    = row_sh_q;
            col_sh_d    = col_sh_q;
        end
    end

    // Stage 1: signed offsets from each latched center, folded to magnitudes
    always_comb begin
        logic [12:0] dx_v;
        logic [12:0] dy_v;
        dx_v  = 13'd0;
        dy_v  = 13'd0;
        adx_d = '0;
        ady_d = '0;
        en_d  = '0;
        for (int i = 0; i < SPRITES; i++) begin
            dx_v     = {1'b0, px.vga_col} - {1'b0, col_sh_q[i]};
            dy_v     = {2'b00, px.vga_row} - {2'b00, row_sh_q[i]};
            adx_d[i] = abs13(dx_v);
            ady_d[i] = abs13(dy_v);
            en_d[i]  = (col_sh_q[i] < H_LIM) && (row_sh_q[i] < V_LIM);
        end
        blank1_d = px.blank;
    end

    // Stage 2: box pre-filter keeps the squares on a few low bits only
    always_comb begin
        logic [D2_W-1:0] lx_v;
        logic [D2_W-1:0] ly_v;
        logic [D2_W-1:0] d2_v;
        lx_v     = '0;
        ly_v     = '0;
        d2_v     = '0;
        hitvec_d = '0;
        for (int i = 0; i < SPRITES; i++) begin
            lx_v        = D2_W'(adx_q[i][SQ_W-1:0]);
            ly_v        = D2_W'(ady_q[i][SQ_W-1:0]);
            d2_v        = lx_v * lx_v + ly_v * ly_v;
            hitvec_d[i] = en_q[i] && (adx_q[i] <= RAD12) && (ady_q[i] <= RAD12)
                          && (d2_v <= RAD_SQ);
        end
        blank2_d = blank1_q;
    end

    // Stage 3: priority select and overlap detect
    always_comb begin
        hit_d       = (|hitvec_q) && !blank2_q;
        idx_d       = hit_d ? lowest_idx(hitvec_q) : '0;
        pix_valid_d = !blank2_q;
        multi_d     = at_least_two(hitvec_q) && !blank2_q;
    end

    // State registers; blank stages reset high so nothing leaves as valid
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SPRITES; i++) begin
                row_sh_q[i] <= ROW_OFF;
                col_sh_q[i] <= COL_OFF;
            end
            adx_q       <= '0;
            ady_q       <= '0;
            en_q        <= '0;
            blank1_q    <= 1'b1;
            hitvec_q    <= '0;
            blank2_q    <= 1'b1;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            pix_valid_q <= 1'b0;
            multi_q     <= 1'b0;
            acc_q       <= 1'b0;
            overlap_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            row_sh_q    <= row_sh_d;
            col_sh_q    <= col_sh_d;
            adx_q       <= adx_d;
            ady_q       <= ady_d;
            en_q        <= en_d;
            blank1_q    <= blank1_d;
            hitvec_q    <= hitvec_d;
            blank2_q    <= blank2_d;
            hit_q       <= hit_d;
            idx_q       <= idx_d;
            pix_valid_q <= pix_valid_d;
            multi_q     <= multi_d;
            acc_q       <= acc_d;
            overlap_q   <= overlap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign px.hit        = hit_q;
    assign px.sprite_idx = idx_q;
    assign px.pix_valid  = pix_valid_q;
    assign frame_count   = frame_cnt_q;
    assign overlap       = overlap_q;
endmodule
